mem_access_ctrl: RTL and testbench

//  Multicycle sequencer for data-memory accesses in the CPU datapath.
//  - Loads: presents the address, waits out memory latency, pulses the MDR write enable, and drives the load-size select (ls_ctrl) so the load-size unit extracts word/half/byte.
//  - Sub-word stores: read-modify-write merge. Word stores: single write.
//  - Sits between the main control FSM (start/done) and the data memory.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/store_merge.sv | 21 ++
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory access sequencer.
// Size encodings, FSM states and the alignment helper.
package mem_pkg;

  localparam logic [1:0] SZ_ILL  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    LATCH,
    WRITE,
    DONE,
    ERR
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    return (sz == SZ_WORD && a != 2'b00) ||
           (sz == SZ_HALF && a[0]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/memory bundle of the access sequencer.
// master = control FSM + memory side, slave = sequencer.
interface mem_access_ctrl_if;

  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mdr_wr;
  logic [1:0]  ls_ctrl;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, is_store, size, addr,
    output store_data, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata,
    input  mdr_wr, ls_ctrl, busy, done, error
  );

  modport slave (
    input  start, is_store, size, addr,
    input  store_data, mem_rdata,
    output mem_addr, mem_wr, mem_wdata,
    output mdr_wr, ls_ctrl, busy, done, error
  );

endinterface

// File: rtl/store_merge.sv
// Read-modify-write merge of store data into the old word.
// Sub-word data always sits in the low lanes.
module store_merge
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = new_i;
    unique case (size_i)
      SZ_HALF: merged_o = {old_i[31:16], new_i[15:0]};
      SZ_BYTE: merged_o = {old_i[31:8], new_i[7:0]};
      default: merged_o = new_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer in front of data memory.
// Define MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  mem_access_ctrl_if.slave bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            st_q;
  logic [1:0]      sz_q;
  logic [31:2]     addr_q;
  logic [31:0]     sdata_q;
  logic            take;
  logic            bad;
  logic [31:0]     merged;

  assign take = (state_q == IDLE) && bus.start;

`ifdef MISALIGN_CHECK_EN
  assign bad = (bus.size == SZ_ILL) ||
               misaligned(bus.size, bus.addr[1:0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign bad = (bus.size == SZ_ILL);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      sz_q    <= SZ_ILL;
      addr_q  <= '0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        st_q    <= bus.is_store;
        sz_q    <= bus.size;
        addr_q  <= bus.addr[31:2];
        sdata_q <= bus.store_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad)
            state_d = ERR;
          else if (bus.is_store && bus.size == SZ_WORD)
            state_d = WRITE;
          else
            state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == LAT_C)
          state_d = st_q ? WRITE : LATCH;
      end
      LATCH:   state_d = DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_rdata is held stable by memory, so RD_WAIT data is valid in WRITE
  store_merge u_merge (
    .size_i   (sz_q),
    .old_i    (bus.mem_rdata),
    .new_i    (sdata_q),
    .merged_o (merged)
  );

  always_comb begin
    bus.mem_addr  = {addr_q, 2'b00};
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    bus.mdr_wr    = 1'b0;
    bus.done      = 1'b0;
    bus.error     = 1'b0;
    bus.busy      = (state_q != IDLE);
    bus.ls_ctrl   = bus.busy ? sz_q : 2'b00;
    unique case (state_q)
      LATCH: bus.mdr_wr = 1'b1;
      WRITE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = merged;
      end
      DONE:    bus.done  = 1'b1;
      ERR:     bus.error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl (MEM_LAT=2).
// Expected traces come from per-operation latency/merge arithmetic.
module tb_mem_access_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic bit exp_err(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'b00) return 1'b1;
`ifdef MISALIGN_CHECK_EN
    if (sz == 2'b01 && a[1:0] != 2'b00) return 1'b1;
    if (sz == 2'b10 && a[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.is_store   = 1'b0;
    bus.size       = 2'b00;
    bus.addr       = '0;
    bus.store_data = '0;
  endtask

  // One operation from a negedge; returns at the negedge of the idle
  // cycle after completion. noisy keeps start high with junk while busy.
  task automatic do_op(string tag, bit st, logic [1:0] sz,
                       logic [31:0] a, logic [31:0] sd,
                       logic [31:0] rd, bit noisy);
    bit          err;
    int          lat;
    logic [31:0] keep, ew;
    logic [6:0]  ev, av;
    err  = exp_err(sz, a);
    lat  = err ? 1 : (st && sz == 2'b01) ? 2 : LAT + 2;
    keep = (sz == 2'b10) ? 32'hFFFF0000 :
           (sz == 2'b11) ? 32'hFFFFFF00 : 32'h0;
    ew   = (rd & keep) | (sd & ~keep);
    bus.start      = 1'b1;
    bus.is_store   = st;
    bus.size       = sz;
    bus.addr       = a;
    bus.store_data = sd;
    bus.mem_rdata  = rd;
    @(posedge clk);
    #1;
    if (!noisy) idle_inputs();
    for (int k = 1; k <= lat + 1; k++) begin
      if (noisy && k <= lat) begin
        bus.start      = 1'b1;
        bus.is_store   = 1'($urandom);
        bus.size       = 2'($urandom);
        bus.addr       = $urandom;
        bus.store_data = $urandom;
      end
      @(negedge clk);
      ev = {k <= lat,
            !err && st && k == lat - 1,
            !err && !st && k == lat - 1,
            !err && k == lat,
            err && k == 1,
            (k <= lat) ? sz : 2'b00};
      av = {bus.busy, bus.mem_wr, bus.mdr_wr, bus.done,
            bus.error, bus.ls_ctrl};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL %s ctl cyc%0d got %b want %b", tag, k, av, ev);
      end
      if (k <= lat && !err) begin
        checks++;
        if (bus.mem_addr !== {a[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s mem_addr cyc%0d got %h want %h",
                   tag, k, bus.mem_addr, {a[31:2], 2'b00});
        end
      end
      if (!err && st && k == lat - 1) begin
        checks++;
        if (bus.mem_wdata !== ew) begin
          errors++;
          $display("FAIL %s mem_wdata got %h want %h",
                   tag, bus.mem_wdata, ew);
        end
      end
      if (noisy && k == lat) idle_inputs();
    end
  endtask

  task automatic test_reset();
    logic [6:0] av;
    reset = 1'b0;
    idle_inputs();
    bus.mem_rdata = 32'h12345678;
    #2;
    av = {bus.busy, bus.mem_wr, bus.mdr_wr, bus.done,
          bus.error, bus.ls_ctrl};
    checks++;
    if (av !== 7'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals got %b %h %h want 0", av,
               bus.mem_addr, bus.mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset busy %b done %b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_load();
    do_op("load_half", 1'b0, 2'b10, 32'h40, 32'h0,
          32'hAABBCCDD, 1'b0);
    do_op("load_byte", 1'b0, 2'b11, 32'h1003, 32'h0,
          32'h01020304, 1'b0);
  endtask

  task automatic test_sub_store();
    do_op("store_byte", 1'b1, 2'b11, 32'h80, 32'h00000055,
          32'h11223344, 1'b0);
    do_op("store_half", 1'b1, 2'b10, 32'h84, 32'hFFFF9876,
          32'h11223344, 1'b0);
  endtask

  task automatic test_word_store();
    do_op("store_word", 1'b1, 2'b01, 32'h100, 32'hDEADBEEF,
          32'h0BADF00D, 1'b0);
  endtask

  task automatic test_illegal();
    do_op("illegal_ld", 1'b0, 2'b00, 32'h20, 32'h0, 32'h5, 1'b0);
    do_op("illegal_st", 1'b1, 2'b00, 32'h24, 32'h77, 32'h5, 1'b0);
  endtask

  task automatic test_misalign();
    do_op("misalign_word", 1'b0, 2'b01, 32'h42, 32'h0,
          32'hCAFEBABE, 1'b0);
    do_op("misalign_half", 1'b1, 2'b10, 32'h47, 32'h1234,
          32'hCAFEBABE, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [6:0] av;
    bus.start      = 1'b1;
    bus.is_store   = 1'b1;
    bus.size       = 2'b10;
    bus.addr       = 32'h60;
    bus.store_data = 32'hABCD;
    bus.mem_rdata  = 32'h99887766;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre busy %b wr %b want 1 0",
               bus.busy, bus.mem_wr);
    end
    reset = 1'b0;
    #1;
    av = {bus.busy, bus.mem_wr, bus.mdr_wr, bus.done,
          bus.error, bus.ls_ctrl};
    checks++;
    if (av !== 7'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outs got %b %h %h want 0", av,
               bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_wr !== 1'b0 || bus.mdr_wr !== 1'b0 ||
          bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after cyc%0d wr %b mdr %b busy %b",
                 k, bus.mem_wr, bus.mdr_wr, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_ld", 1'b0, 2'b01, 32'h200, 32'h0, 32'h1, 1'b1);
    do_op("b2b_sw", 1'b1, 2'b01, 32'h204, 32'h2, 32'h3, 1'b1);
    do_op("b2b_sb", 1'b1, 2'b11, 32'h208, 32'hFF, 32'h4, 1'b1);
    do_op("b2b_err", 1'b0, 2'b00, 32'h20C, 32'h0, 32'h5, 1'b1);
    do_op("b2b_lh", 1'b0, 2'b10, 32'h210, 32'h0, 32'h6, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_op("rand", 1'($urandom), 2'($urandom), $urandom,
            $urandom, $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_sub_store();
    test_word_store();
    test_illegal();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
